// File: rtl/sysid_check_pkg.sv
// sysid_check_pkg: shared FSM states, Avalon word addresses and stall-counter width
package sysid_check_pkg;
    typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, CHECK, FIN} state_t;
    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;
    localparam int   STALL_W = 16;
endpackage

// File: rtl/sysid_check_master.sv
// sysid_check_master: reads system ID and timestamp over Avalon-MM and checks them against expected values
// Ports: clock/reset (async, active-high), start pulse; avm_address/avm_read/avm_readdata/avm_waitrequest
// master port; busy, done pulse, sticky pass and err_timeout, captured id_value/ts_value.
// Optional read timeout enabled by defining SYSID_CHECK_TIMEOUT_EN.
module sysid_check_master
    import sysid_check_pkg::*;
#(
    parameter logic [31:0]        EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0]        EXPECTED_TS    = 32'h5896_920A,
    parameter logic [STALL_W-1:0] TIMEOUT_CYCLES = 16'd255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        err_timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);
`ifdef SYSID_CHECK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    state_t state, next;
    logic [STALL_W-1:0] stall_cnt;
    logic ack, timeout_hit, entering;
    always_comb begin
        avm_read    = (state == RD_ID) || (state == RD_TS);
        avm_address = (state == RD_TS) ? ADDR_TS : ADDR_ID;
        ack         = avm_read && !avm_waitrequest;
        // a read that accepts data never times out, even on the limit cycle
        timeout_hit = TO_EN && avm_read && avm_waitrequest && (stall_cnt >= TIMEOUT_CYCLES);
        next        = state;
        case (state)
            IDLE:    next = start ? RD_ID : IDLE;
            RD_ID:   next = ack ? RD_TS : timeout_hit ? FIN : RD_ID;
            RD_TS:   next = ack ? CHECK : timeout_hit ? FIN : RD_TS;
            CHECK:   next = FIN;
            default: next = IDLE;
        endcase
        entering = (next != state) && ((next == RD_ID) || (next == RD_TS));
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            stall_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            id_value  <= '0;
            ts_value  <= '0;
        end else begin
            state     <= next;
            done      <= (state == FIN);
            stall_cnt <= entering ? '0 :
                         (avm_read && avm_waitrequest && !(&stall_cnt)) ? stall_cnt + 1'b1 : stall_cnt;
            if (state == IDLE && start) begin
                busy <= 1'b1;
                pass <= 1'b0;
            end
            if (state == FIN) busy <= 1'b0;
            if (state == RD_ID && ack) id_value <= avm_readdata;
            if (state == RD_TS && ack) ts_value <= avm_readdata;
            if (state == CHECK) pass <= (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
            if (timeout_hit) pass <= 1'b0;
        end
    end
`ifdef SYSID_CHECK_TIMEOUT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) err_timeout <= 1'b0;
        else if (state == IDLE && start) err_timeout <= 1'b0;
        else if (timeout_hit) err_timeout <= 1'b1;
    end
`else
    assign err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_sysid_check_master.sv
// tb_sysid_check_master: randomized self-checking bench with a behavioural slave and timing model
module tb_sysid_check_master;
    localparam logic [31:0] EID = 32'h0000_0000;
    localparam logic [31:0] ETS = 32'h5896_920A;
    logic        clock = 1'b0, reset = 1'b1, start = 1'b0;
    logic        avm_address, avm_read, avm_waitrequest;
    logic        busy, done, pass, err_timeout;
    logic [31:0] avm_readdata, id_value, ts_value;
    logic [31:0] idw = EID, tsw = ETS;
    int          wait_n = 0;
    bit          stuck = 1'b0;
    int          sctr = 0, reads = 0;
    int          checks = 0, errors = 0;

    sysid_check_master #(.EXPECTED_ID(EID), .EXPECTED_TS(ETS), .TIMEOUT_CYCLES(16'd8)) dut (
        .clock(clock), .reset(reset), .start(start),
        .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest), .busy(busy), .done(done), .pass(pass),
        .err_timeout(err_timeout), .id_value(id_value), .ts_value(ts_value)
    );

    always #5 clock = ~clock;

    // slave: stalls wait_n cycles per read (or forever when stuck), returns idw/tsw by address
    assign avm_readdata    = avm_address ? tsw : idw;
    assign avm_waitrequest = avm_read && (stuck || sctr < wait_n);
    always @(posedge clock) begin
        sctr <= (avm_read && avm_waitrequest) ? sctr + 1 : 0;
        if (avm_read && !avm_waitrequest) reads <= reads + 1;
    end

    // pulse start, then count cycles until done; records whether a stalled read changed between cycles
    task automatic run_seq(input int extra, input int bound, input bit chk_stab,
                           output int lat, output int stab_bad, output logic busy0, output logic pass0);
        logic st, a;
        lat = -1;
        stab_bad = 0;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        busy0 = busy;
        pass0 = pass;
        for (int k = 1; k <= bound; k++) begin
            st = avm_read && avm_waitrequest;
            a  = avm_address;
            @(posedge clock);
            #1;
            start = (k == extra);
            if (chk_stab && st && (avm_read !== 1'b1 || avm_address !== a)) stab_bad++;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({avm_read, avm_address, busy, done, pass, err_timeout} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 000000", {avm_read, avm_address, busy, done, pass, err_timeout});
        end
        checks++;
        if ({id_value, ts_value} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0", {id_value, ts_value});
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_zero_wait();
        int lat, sb, r0;
        logic b0, p0;
        idw = EID; tsw = ETS; wait_n = 0; r0 = reads;
        run_seq(0, 50, 1'b1, lat, sb, b0, p0);
        checks++;
        if (b0 !== 1'b1) begin errors++; $display("FAIL zw_busy got %b exp 1", b0); end
        checks++;
        if (lat != 4) begin errors++; $display("FAIL zw_latency got %0d exp 4", lat); end
        checks++;
        if ({pass, err_timeout} !== 2'b10) begin errors++; $display("FAIL zw_pass got %b exp 10", {pass, err_timeout}); end
        checks++;
        if (id_value !== EID || ts_value !== ETS) begin
            errors++; $display("FAIL zw_values got %h/%h exp %h/%h", id_value, ts_value, EID, ETS);
        end
        checks++;
        if (reads - r0 != 2) begin errors++; $display("FAIL zw_reads got %0d exp 2", reads - r0); end
        @(posedge clock);
        #1;
        checks++;
        if ({done, busy} !== 2'b00) begin errors++; $display("FAIL zw_after got %b exp 00", {done, busy}); end
    endtask

    task automatic test_bad_ts();
        int lat, sb;
        logic b0, p0;
        idw = EID; tsw = 32'h5896_920B; wait_n = 0;
        run_seq(0, 50, 1'b1, lat, sb, b0, p0);
        checks++;
        if (p0 !== 1'b0) begin errors++; $display("FAIL bad_pass_cleared got %b exp 0", p0); end
        checks++;
        if (lat != 4) begin errors++; $display("FAIL bad_latency got %0d exp 4", lat); end
        checks++;
        if ({pass, err_timeout} !== 2'b00) begin errors++; $display("FAIL bad_pass got %b exp 00", {pass, err_timeout}); end
        checks++;
        if (ts_value !== 32'h5896_920B) begin errors++; $display("FAIL bad_ts got %h exp 5896920b", ts_value); end
    endtask

    task automatic test_wait3();
        int lat, sb;
        logic b0, p0;
        idw = EID; tsw = ETS; wait_n = 3;
        run_seq(0, 50, 1'b1, lat, sb, b0, p0);
        checks++;
        if (lat != 10) begin errors++; $display("FAIL w3_latency got %0d exp 10", lat); end
        checks++;
        if (sb != 0) begin errors++; $display("FAIL w3_stable got %0d changes exp 0", sb); end
        checks++;
        if (pass !== 1'b1) begin errors++; $display("FAIL w3_pass got %b exp 1", pass); end
    endtask

    task automatic test_random();
        int lat, sb, r0;
        logic b0, p0, exp_pass;
        for (int i = 0; i < 10; i++) begin
            wait_n = $urandom_range(0, 5);
            idw = ($urandom_range(0, 2) == 0) ? $urandom : EID;
            tsw = ($urandom_range(0, 2) == 0) ? (ETS ^ (32'h1 << $urandom_range(0, 31))) : ETS;
            exp_pass = (idw == EID) && (tsw == ETS);
            r0 = reads;
            run_seq(0, 100, 1'b1, lat, sb, b0, p0);
            checks++;
            if (lat != 4 + 2 * wait_n) begin errors++; $display("FAIL rnd_latency[%0d] got %0d exp %0d", i, lat, 4 + 2 * wait_n); end
            checks++;
            if (pass !== exp_pass) begin errors++; $display("FAIL rnd_pass[%0d] got %b exp %b", i, pass, exp_pass); end
            checks++;
            if (id_value !== idw || ts_value !== tsw) begin
                errors++; $display("FAIL rnd_values[%0d] got %h/%h exp %h/%h", i, id_value, ts_value, idw, tsw);
            end
            checks++;
            if (sb != 0 || reads - r0 != 2) begin
                errors++; $display("FAIL rnd_bus[%0d] got %0d changes %0d reads exp 0/2", i, sb, reads - r0);
            end
        end
    endtask

    task automatic test_timeout();
        int lat, sb, r0;
        logic b0, p0;
        idw = EID; tsw = ETS; wait_n = 0; stuck = 1'b1; r0 = reads;
`ifdef SYSID_CHECK_TIMEOUT_EN
        run_seq(0, 50, 1'b0, lat, sb, b0, p0);
        checks++;
        if (lat != 10) begin errors++; $display("FAIL to_latency got %0d exp 10", lat); end
        checks++;
        if ({err_timeout, pass, avm_read} !== 3'b100) begin
            errors++; $display("FAIL to_flags got %b exp 100", {err_timeout, pass, avm_read});
        end
        checks++;
        if (reads - r0 != 0) begin errors++; $display("FAIL to_reads got %0d exp 0", reads - r0); end
        stuck = 1'b0;
`else
        run_seq(0, 40, 1'b1, lat, sb, b0, p0);
        checks++;
        if (lat != -1 || {err_timeout, busy, avm_read} !== 3'b011) begin
            errors++; $display("FAIL nto_stall got lat %0d flags %b exp -1 011", lat, {err_timeout, busy, avm_read});
        end
        @(negedge clock);
        stuck = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) begin lat = k; break; end
        end
        checks++;
        if (lat != 4 || pass !== 1'b1 || err_timeout !== 1'b0) begin
            errors++; $display("FAIL nto_release got lat %0d pass %b err %b exp 4 1 0", lat, pass, err_timeout);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int lat, sb, seen;
        logic b0, p0;
        idw = 32'hDEAD_BEEF; tsw = ETS; wait_n = 30;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        seen = 0;
        for (int k = 0; k < 200 && avm_address !== 1'b1; k++) begin
            @(posedge clock);
            #1;
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({avm_read, avm_address, busy, done, pass, err_timeout} !== 6'b0 || {id_value, ts_value} !== 64'h0) begin
            errors++;
            $display("FAIL mid_reset got %b %h exp 0", {avm_read, avm_address, busy, done, pass, err_timeout}, {id_value, ts_value});
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (8) begin
            @(posedge clock);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL mid_nodone got %0d active cycles exp 0", seen); end
        idw = EID; wait_n = 0;
        run_seq(0, 50, 1'b1, lat, sb, b0, p0);
        checks++;
        if (lat != 4 || pass !== 1'b1) begin errors++; $display("FAIL mid_rerun got lat %0d pass %b exp 4 1", lat, pass); end
    endtask

    task automatic test_busy_start();
        int lat, sb, r0, extra_done;
        logic b0, p0;
        idw = EID; tsw = ETS; wait_n = 1; r0 = reads;
        run_seq(2, 50, 1'b1, lat, sb, b0, p0);
        checks++;
        if (lat != 6) begin errors++; $display("FAIL bs_latency got %0d exp 6", lat); end
        extra_done = 0;
        repeat (10) begin
            @(posedge clock);
            #1;
            if (done === 1'b1 || busy === 1'b1) extra_done++;
        end
        checks++;
        if (extra_done != 0 || reads - r0 != 2) begin
            errors++; $display("FAIL bs_ignored got %0d active %0d reads exp 0/2", extra_done, reads - r0);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_bad_ts();
        test_wait3();
        test_random();
        test_timeout();
        test_reset_mid();
        test_busy_start();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sysid_check_master.md
SYSID_CHECK_MASTER -- requirements
Module: sysid_check_master

Interface
REQ-001 Parameter EXPECTED_ID, default 32'h0000_0000, expected system ID word (read at address 0).
REQ-002 Parameter EXPECTED_TS, default 32'h5896_920A, expected timestamp word (read at address 1).
REQ-003 Parameter TIMEOUT_CYCLES, default 16'd255, maximum wait-stall cycles per read.
REQ-004 clock  in  1  single clock; all logic rising-edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; begins a check sequence when idle.
REQ-007 avm_address  out  1  Avalon-MM word address (0 = ID, 1 = timestamp).
REQ-008 avm_read  out  1  Avalon-MM read strobe.
REQ-009 avm_readdata  in  32  read data, valid when avm_read=1 and avm_waitrequest=0.
REQ-010 avm_waitrequest  in  1  slave stall; tie 0 for zero-wait slaves.
REQ-011 busy  out  1  sequence in progress.
REQ-012 done  out  1  one-cycle pulse at sequence end.
REQ-013 pass  out  1  sticky result: both words matched, no timeout.
REQ-014 err_timeout  out  1  sticky: a read exceeded TIMEOUT_CYCLES.
REQ-015 id_value, ts_value  out  32 each  captured read data.

Function
REQ-016 The FSM SHALL have states IDLE, RD_ID, RD_TS, CHECK, FIN.
REQ-017 In IDLE, start=1 SHALL move to RD_ID next cycle, clear pass/err_timeout, and set busy; start while busy SHALL be ignored.
REQ-018 In RD_ID the block SHALL drive avm_read=1 and avm_address=0, holding both stable while avm_waitrequest=1.
REQ-019 On avm_read=1 and avm_waitrequest=0 in RD_ID, id_value SHALL capture avm_readdata and the FSM SHALL go to RD_TS; a zero-wait slave therefore gives one cycle per read.
REQ-020 RD_TS SHALL behave identically with avm_address=1, capture into ts_value, then go to CHECK.
REQ-021 CHECK SHALL set pass=(id_value==EXPECTED_ID)&&(ts_value==EXPECTED_TS), then go to FIN; start-to-done latency with zero waits SHALL be 4 cycles.
REQ-022 FIN SHALL pulse done for one cycle, clear busy, and return to IDLE.
REQ-023 avm_read SHALL be 0 in IDLE, CHECK and FIN; avm_address SHALL be 0 outside RD_TS.
REQ-024 A 16-bit stall counter SHALL reset on entering each read state, increment per stalled cycle, and saturate (no wrap).
REQ-025 Reset asserted mid-sequence SHALL abort immediately to IDLE with no done pulse.

Reset
REQ-026 On reset: state=IDLE, avm_read=0, avm_address=0, busy=0, done=0, pass=0, err_timeout=0, id_value=0, ts_value=0, stall counter=0.

Configuration
REQ-027 Macro SYSID_CHECK_TIMEOUT_EN defined: when the stall counter reaches TIMEOUT_CYCLES in a read state, the block SHALL drop avm_read, set err_timeout=1 and pass=0, and go to FIN.
REQ-028 Macro undefined: no timeout; err_timeout SHALL be tied 0 and reads SHALL wait indefinitely.

Structure
REQ-029 A shared package sysid_check_pkg SHALL hold the FSM state enum, the address constants ADDR_ID=0/ADDR_TS=1, and the stall-counter width.
REQ-030 No sub-module is required; the stall counter SHALL stay inline.

Verification
REQ-031 Zero-wait slave returning 0 / 32'h5896_920A, start pulse -> done 4 cycles later, pass=1, id_value=0, ts_value=32'h5896_920A.
REQ-032 Slave returns 32'h5896_920B at address 1 -> done, pass=0, err_timeout=0.
REQ-033 waitrequest held 3 cycles on each read -> address/read stable while stalled, done 10 cycles after start, pass=1.
REQ-034 With SYSID_CHECK_TIMEOUT_EN and TIMEOUT_CYCLES=8, waitrequest stuck high -> err_timeout=1, pass=0, done after about 10 cycles, avm_read=0 afterwards.
REQ-035 Reset asserted during RD_TS -> outputs return to reset values next edge, no done pulse; a later start completes normally.
REQ-036 start pulsed while busy -> ignored, only one done pulse, no extra reads observed.
